fmdll_lock_ctrl: RTL and testbench
==================================

# fmdll_lock_ctrl

Lock-sequencing controller for the FMDLL frequency-multiplying DLL. It accepts ratio change requests (M, N), drives the M/N configuration and the delay-line code into the FMDLL, and acquires lock with a binary (SAR) search on the phase-detector output. After lock it optionally tracks drift. It sits between the system configuration logic and the FMDLL core, clocked by the FMDLL reference clock.

## Interface
- DW, 6: delay-code width in bits.
- SETTLE_CYC, 8: cycles waited after each code change before sampling the phase detector (≥2).
- WIN_LOG, 3: tracking vote window is 2^WIN_LOG cycles.
- CLK_exit  in  1  reference clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-high reset (asserted = 1).
- cfg_req  in  1  level request, held until cfg_ack or cfg_err.
- cfg_M  in  2  requested M; sampled on acceptance.
- cfg_N  in  4  requested N; sampled on acceptance.
- pd_late  in  1  phase detector: delay line too long.
- pd_early  in  1  phase detector: delay line too short.
- M  out  2  FMDLL M setting.
- N  out  4  FMDLL N setting.
- dly_code  out  DW  FMDLL delay-line code.
- dll_en  out  1  FMDLL enable.
- locked  out  1  lock achieved.
- busy  out  1  controller in APPLY or SAR.
- cfg_ack  out  1  one-cycle pulse: request applied.
- cfg_err  out  1  one-cycle pulse: request rejected (cfg_N == 0).

## Operation
- States: IDLE, APPLY, SAR, TRACK.
- Reset: state IDLE, all outputs 0. Reset asserted mid-search aborts immediately; dly_code returns to 0.
- Acceptance: cfg_req = 1 while cfg_ack = 0 and cfg_err = 0, in any state.
  - cfg_N == 0: cfg_err pulses; state, M, N, dly_code and locked are unchanged.
  - Otherwise: go to APPLY and abort any search or tracking in progress.
- APPLY (1 cycle): latch M and N, dly_code = 0, dll_en = 0, locked = 0, busy = 1, cfg_ack = 1. Next state is SAR.
- SAR: dll_en = 1, busy = 1. For bit b from DW-1 down to 0:
  - set bit b of dly_code;
  - wait SETTLE_CYC cycles;
  - on the last of those cycles, clear bit b if pd_late = 1, otherwise keep it.
  - After bit 0, go to TRACK.
- TRACK: locked = 1, busy = 0, dll_en = 1.
  - Votes: pd_late = +1, pd_early = -1; both asserted or neither = 0.
  - At the end of each window, compare the signed vote sum:
    - sum > 0: decrement dly_code, saturating at 0;
    - sum < 0: increment dly_code, saturating at 2^DW-1;
    - sum = 0: no change.
  - The vote accumulator clears at the start of each window.
- Simultaneous events:
  - Acceptance has priority over a window-end update or a SAR bit decision in the same cycle.
  - A request already pending when reset deasserts is accepted on the first cycle after reset.

## Timing
- Acceptance at cycle t: cfg_ack, new M and N, and dly_code = 0 are visible at t+1.
- First SAR code (MSB only) is visible at t+2.
- locked rises at t+2+DW·SETTLE_CYC. With default parameters that is t+50.
- cfg_err pulse is visible at t+1.
- The requester drops cfg_req within 1 cycle of the ack/err pulse. A request held longer is accepted again.
- Tracking: dly_code changes at most once per 2^WIN_LOG cycles, one cycle after the window's last sample.
- Vote accumulator width: WIN_LOG+2 bits, signed.

## Configuration
- FMDLL_TRACK_EN
  - Defined: TRACK performs the window voting and ±1 code updates described above.
  - Undefined: dly_code is frozen at the SAR result, pd inputs are ignored in TRACK, and no vote counter is synthesized.
  - Both cases: locked = 1 in TRACK.

## Test plan
- Reset then idle: rst_n = 1 for 3 cycles, then 0 → all outputs 0, state IDLE, no cfg_ack.
- Basic lock: cfg_M = 3, cfg_N = 10; behavioural PD model asserts pd_late when dly_code > 37 → cfg_ack at t+1, M = 3 and N = 10 at t+1, locked at t+50, dly_code = 37.
- Reject: cfg_N = 0 while locked with code 37 → cfg_err one cycle; M, N, code and locked unchanged.
- Re-request mid-SAR: second request (M = 1, N = 4) at cycle t+20 → locked drops, code = 0 at t+21, new lock at t+70.
- Tracking (FMDLL_TRACK_EN defined): locked at 37, pd_late held high 3 windows → code 36, 35, 34, then saturate test from 1 reaches 0 and holds. Without the macro → code stays 37.
- Priority: request asserted on the same cycle as a window end → cfg_ack follows, no tracking update applied.

Source files
------------

// File: rtl/fmdll_lock_ctrl_if.sv
// Ratio-change request handshake between the system configuration logic and fmdll_lock_ctrl.
// The requester holds cfg_req until it sees a one-cycle cfg_ack or cfg_err.
interface fmdll_lock_ctrl_if;
    logic       cfg_req;
    logic [1:0] cfg_M;
    logic [3:0] cfg_N;
    logic       cfg_ack;
    logic       cfg_err;

    modport master (
        output cfg_req,
        output cfg_M,
        output cfg_N,
        input  cfg_ack,
        input  cfg_err
    );

    modport slave (
        input  cfg_req,
        input  cfg_M,
        input  cfg_N,
        output cfg_ack,
        output cfg_err
    );
endinterface

// File: rtl/fmdll_lock_ctrl.sv
// FMDLL lock sequencer: applies M/N ratio requests, then acquires lock with a SAR search on the PD.
// Drift tracking after lock (windowed PD voting, +/-1 code steps) is built only with `define FMDLL_TRACK_EN.
module fmdll_lock_ctrl #(
    parameter int DW         = 6,
    parameter int SETTLE_CYC = 8,
    parameter int WIN_LOG    = 3
) (
    input  logic             CLK_exit,
    input  logic             rst_n,
    fmdll_lock_ctrl_if.slave cfg,
    input  logic             pd_late,
    input  logic             pd_early,
    output logic [1:0]       M,
    output logic [3:0]       N,
    output logic [DW-1:0]    dly_code,
    output logic             dll_en,
    output logic             locked,
    output logic             busy
);
    localparam int BW = (DW > 1) ? $clog2(DW) : 1;
    localparam int CW = $clog2(SETTLE_CYC);
    localparam logic [BW-1:0] BIT_MSB  = BW'(DW - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {IDLE, APPLY, SAR, TRACK} state_t;

    state_t        r_state, w_state;
    logic [1:0]    r_M, w_M;
    logic [3:0]    r_N, w_N;
    logic [DW-1:0] r_code, w_code;
    logic          r_ack, w_ack;
    logic          r_err, w_err;
    logic [BW-1:0] r_bit, w_bit;
    logic [CW-1:0] r_cnt, w_cnt;
    logic          w_accept;

`ifdef FMDLL_TRACK_EN
    localparam int AW = WIN_LOG + 2;
    localparam logic [WIN_LOG-1:0] WIN_LAST = '1;
    logic signed [AW-1:0] r_acc, w_acc, w_vote, w_sum;
    logic [WIN_LOG-1:0]   r_win, w_win;

    // Late votes to shorten the line, early votes to lengthen it; both or neither cancel.
    assign w_vote = (pd_late && !pd_early) ? AW'(1) :
                    (!pd_late && pd_early) ? '1 : '0;
    assign w_sum  = r_acc + w_vote;
`else
    logic w_unused_pd;
    assign w_unused_pd = pd_early;
`endif

    // A request is taken only while no ack/err pulse is showing, so a held level is not double-counted.
    assign w_accept = cfg.cfg_req && !r_ack && !r_err;

    always_comb begin
        w_state = r_state;
        w_M     = r_M;
        w_N     = r_N;
        w_code  = r_code;
        w_ack   = 1'b0;
        w_err   = 1'b0;
        w_bit   = r_bit;
        w_cnt   = r_cnt;
`ifdef FMDLL_TRACK_EN
        w_acc   = r_acc;
        w_win   = r_win;
`endif
        if (w_accept) begin
            if (cfg.cfg_N == 4'd0) begin
                w_err = 1'b1;
            end else begin
                w_state = APPLY;
                w_M     = cfg.cfg_M;
                w_N     = cfg.cfg_N;
                w_code  = '0;
                w_ack   = 1'b1;
            end
        end else begin
            case (r_state)
                APPLY: begin
                    w_state         = SAR;
                    w_code          = '0;
                    w_code[DW-1]    = 1'b1;
                    w_bit           = BIT_MSB;
                    w_cnt           = '0;
                end
                SAR: begin
                    if (r_cnt == CNT_LAST) begin
                        w_cnt = '0;
                        if (pd_late) w_code[r_bit] = 1'b0;
                        if (r_bit == '0) begin
                            w_state = TRACK;
`ifdef FMDLL_TRACK_EN
                            w_acc   = '0;
                            w_win   = '0;
`endif
                        end else begin
                            w_bit                  = r_bit - 1'b1;
                            w_code[r_bit - 1'b1]   = 1'b1;
                        end
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
                TRACK: begin
`ifdef FMDLL_TRACK_EN
                    if (r_win == WIN_LAST) begin
                        w_win = '0;
                        w_acc = '0;
                        if (w_sum > 0 && r_code != '0)
                            w_code = r_code - 1'b1;
                        else if (w_sum < 0 && r_code != '1)
                            w_code = r_code + 1'b1;
                    end else begin
                        w_win = r_win + 1'b1;
                        w_acc = w_sum;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK_exit) begin
        if (rst_n) begin
            r_state <= IDLE;
            r_M     <= '0;
            r_N     <= '0;
            r_code  <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_bit   <= '0;
            r_cnt   <= '0;
`ifdef FMDLL_TRACK_EN
            r_acc   <= '0;
            r_win   <= '0;
`endif
        end else begin
            r_state <= w_state;
            r_M     <= w_M;
            r_N     <= w_N;
            r_code  <= w_code;
            r_ack   <= w_ack;
            r_err   <= w_err;
            r_bit   <= w_bit;
            r_cnt   <= w_cnt;
`ifdef FMDLL_TRACK_EN
            r_acc   <= w_acc;
            r_win   <= w_win;
`endif
        end
    end

    assign M           = r_M;
    assign N           = r_N;
    assign dly_code    = r_code;
    assign dll_en      = (r_state == SAR) || (r_state == TRACK);
    assign locked      = (r_state == TRACK);
    assign busy        = (r_state == APPLY) || (r_state == SAR);
    assign cfg.cfg_ack = r_ack;
    assign cfg.cfg_err = r_err;
endmodule

// File: tb/tb_fmdll_lock_ctrl.sv
// Bench for fmdll_lock_ctrl: directed lock/reject/abort/track/priority scenarios, then random traffic,
// all compared every cycle against a cycle-age behavioural model.
module tb_fmdll_lock_ctrl;
    localparam int DW       = 6;
    localparam int S        = 8;
    localparam int WIN_LOG  = 3;
    localparam int W        = 1 << WIN_LOG;
    localparam int LOCK_AGE = 2 + DW * S;
`ifdef FMDLL_TRACK_EN
    localparam int TRK1 = 36, TRK2 = 35, TRK3 = 34, SAT = 0;
`else
    localparam int TRK1 = 37, TRK2 = 37, TRK3 = 37, SAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pd_late, pd_early;
    logic [1:0]    M;
    logic [3:0]    N;
    logic [DW-1:0] dly_code;
    logic          dll_en, locked, busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   pd_mode;
    int   target;
    logic f_late, f_early;

    fmdll_lock_ctrl_if u_if();

    fmdll_lock_ctrl #(.DW(DW), .SETTLE_CYC(S), .WIN_LOG(WIN_LOG)) dut (
        .CLK_exit (clk),
        .rst_n    (rst_n),
        .cfg      (u_if),
        .pd_late  (pd_late),
        .pd_early (pd_early),
        .M        (M),
        .N        (N),
        .dly_code (dly_code),
        .dll_en   (dll_en),
        .locked   (locked),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Phase detector: ideal line length "target" (mode 0), or forced / random levels.
    assign pd_late  = (pd_mode == 0) ? (int'(dly_code) > target) : f_late;
    assign pd_early = (pd_mode == 0) ? (int'(dly_code) < target) : f_early;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Model: m_age counts visible cycles since the last acceptance (1 = apply cycle).
    bit m_valid = 0;
    bit m_idle;
    int m_age, m_code, m_M, m_N, m_sum;
    bit m_ack, m_err;

    always @(posedge clk) begin
        bit acc;
        int b, v;
        if (rst_n === 1'b1) begin
            m_valid = 1; m_idle = 1; m_age = 0; m_code = 0; m_M = 0; m_N = 0;
            m_ack = 0; m_err = 0; m_sum = 0;
        end else if (m_valid) begin
            acc   = u_if.cfg_req && !m_ack && !m_err;
            m_ack = 0;
            m_err = 0;
            if (acc && u_if.cfg_N == 0) begin
                m_err = 1;
            end else if (acc) begin
                m_idle = 0; m_age = 1; m_M = u_if.cfg_M; m_N = u_if.cfg_N; m_code = 0; m_ack = 1;
            end else if (!m_idle) begin
                if (m_age == 1) begin
                    m_code = 1 << (DW - 1);
                end else if (m_age < LOCK_AGE) begin
                    b = DW - 1 - (m_age - 2) / S;
                    if ((m_age - 2) % S == S - 1) begin
                        if (pd_late) m_code -= (1 << b);
                        if (b > 0) m_code += (1 << (b - 1));
                        else m_sum = 0;
                    end
                end else begin
`ifdef FMDLL_TRACK_EN
                    v = (pd_late && !pd_early) ? 1 : ((!pd_late && pd_early) ? -1 : 0);
                    m_sum += v;
                    if ((m_age - LOCK_AGE) % W == W - 1) begin
                        if (m_sum > 0 && m_code > 0) m_code--;
                        else if (m_sum < 0 && m_code < (1 << DW) - 1) m_code++;
                        m_sum = 0;
                    end
`else
                    v = 0;
`endif
                end
                m_age++;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("M",        M,            m_M);
            chk("N",        N,            m_N);
            chk("dly_code", dly_code,     m_code);
            chk("dll_en",   dll_en,       !m_idle && m_age >= 2);
            chk("locked",   locked,       !m_idle && m_age >= LOCK_AGE);
            chk("busy",     busy,         !m_idle && m_age < LOCK_AGE);
            chk("cfg_ack",  u_if.cfg_ack, m_ack);
            chk("cfg_err",  u_if.cfg_err, m_err);
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            if (pd_mode == 2) begin
                f_late  = 1'($urandom);
                f_early = 1'($urandom);
            end
        end
    endtask

    // Called at a negedge of cycle t; returns at the negedge of t+1 with the request dropped.
    task automatic do_req(input logic [1:0] m, input logic [3:0] n);
        u_if.cfg_req = 1'b1;
        u_if.cfg_M   = m;
        u_if.cfg_N   = n;
        @(negedge clk);
        u_if.cfg_req = 1'b0;
    endtask

    initial begin
        int act, hold;
        pd_mode = 0; target = 37; f_late = 0; f_early = 0;
        u_if.cfg_req = 0; u_if.cfg_M = 0; u_if.cfg_N = 0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        chk("rst_code", dly_code, 0);
        chk("rst_locked", locked, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dll_en", dll_en, 0);
        chk("rst_M", M, 0);
        wait_cycles(3);
        chk("idle_ack", u_if.cfg_ack, 0);
        chk("idle_busy", busy, 0);

        // Basic lock to 37
        do_req(2'd3, 4'd10);
        chk("ack_t1", u_if.cfg_ack, 1);
        chk("M_t1", M, 3);
        chk("N_t1", N, 10);
        chk("code_t1", dly_code, 0);
        wait_cycles(1);
        chk("code_t2", dly_code, 32);
        wait_cycles(47);
        chk("locked_t49", locked, 0);
        wait_cycles(1);
        chk("locked_t50", locked, 1);
        chk("code_t50", dly_code, 37);

        // Reject N == 0
        wait_cycles(5);
        do_req(2'd1, 4'd0);
        chk("err_pulse", u_if.cfg_err, 1);
        chk("err_no_ack", u_if.cfg_ack, 0);
        chk("err_code", dly_code, 37);
        chk("err_locked", locked, 1);
        chk("err_M", M, 3);
        chk("err_N", N, 10);
        wait_cycles(1);
        chk("err_one_cycle", u_if.cfg_err, 0);

        // Re-request mid-SAR at t+20
        do_req(2'd3, 4'd10);
        wait_cycles(19);
        do_req(2'd1, 4'd4);
        chk("abort_ack", u_if.cfg_ack, 1);
        chk("abort_code", dly_code, 0);
        chk("abort_locked", locked, 0);
        chk("abort_M", M, 1);
        chk("abort_N", N, 4);
        wait_cycles(48);
        chk("relock_t69", locked, 0);
        wait_cycles(1);
        chk("relock_t70", locked, 1);
        chk("relock_code", dly_code, 37);

        // Tracking with pd_late held high
        do_req(2'd3, 4'd10);
        wait_cycles(49);
        chk("trk_locked", locked, 1);
        pd_mode = 1; f_late = 1; f_early = 0;
        wait_cycles(8);
        chk("trk_win1", dly_code, TRK1);
        wait_cycles(8);
        chk("trk_win2", dly_code, TRK2);
        wait_cycles(8);
        chk("trk_win3", dly_code, TRK3);
        chk("trk_still_locked", locked, 1);

        // Saturation at zero
        pd_mode = 0; target = 1;
        do_req(2'd2, 4'd5);
        wait_cycles(49);
        chk("sat_lock_code", dly_code, 1);
        pd_mode = 1; f_late = 1; f_early = 0;
        wait_cycles(8);
        chk("sat_win1", dly_code, SAT);
        wait_cycles(8);
        chk("sat_win2", dly_code, SAT);

        // Request on the window-end cycle wins over the tracking update
        pd_mode = 0; target = 37;
        do_req(2'd3, 4'd10);
        wait_cycles(49);
        pd_mode = 1; f_late = 1; f_early = 0;
        wait_cycles(7);
        do_req(2'd0, 4'd7);
        chk("prio_ack", u_if.cfg_ack, 1);
        chk("prio_code", dly_code, 0);
        chk("prio_N", N, 7);

        // Random traffic
        for (int it = 0; it < 60; it++) begin
            act = $urandom_range(0, 9);
            if (act < 5) begin
                u_if.cfg_M   = 2'($urandom);
                u_if.cfg_N   = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                u_if.cfg_req = 1'b1;
                hold = $urandom_range(1, 3);
                wait_cycles(hold);
                u_if.cfg_req = 1'b0;
            end else if (act < 9) begin
                pd_mode = $urandom_range(0, 2);
                target  = $urandom_range(0, 63);
                f_late  = 1'($urandom);
                f_early = 1'($urandom);
                wait_cycles($urandom_range(1, 90));
            end else begin
                u_if.cfg_req = 1'($urandom);
                u_if.cfg_N   = 4'($urandom_range(1, 15));
                rst_n = 1'b1;
                wait_cycles($urandom_range(1, 2));
                rst_n = 1'b0;
                wait_cycles(1);
                u_if.cfg_req = 1'b0;
            end
        end
        wait_cycles(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
